// File: rtl/ram_pkg.sv
// Shared sizing and state encoding for the word-copy engine and its RAM.
package ram_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/ram_sync.sv
// Single-port synchronous RAM: write on we, read data one cycle after addr.
// Read-before-write on a same-address access; no backpressure.
module ram_sync #(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ram_copier.sv
// Copies len words src->dst through one synchronous-read RAM port, 3 cycles/word + 1 done cycle.
// Start is only sampled in IDLE; no backpressure, the RAM is assumed always available.
module ram_copier #(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              writeOn,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out
);

   import ram_pkg::*;

   localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, dst_q, i_q;
   logic [ADDR_W:0]   len_q;
   logic [DATA_W-1:0] word_q;
   logic [ADDR_W:0]   len_clamped;
   logic [ADDR_W:0]   i_next;

   assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
   assign i_next      = {1'b0, i_q} + {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Outputs are decoded from state so reset clears the RAM strobe without waiting for a clock.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      writeOn = 1'b0;
      address = '0;
      data_in = '0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (len_clamped == '0) ? DONE : READ;
         end
         READ: begin
            busy    = 1'b1;
            address = src_q + i_q;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            busy    = 1'b1;
            address = src_q + i_q;
            state_d = WRITE;
         end
         WRITE: begin
            busy    = 1'b1;
            writeOn = 1'b1;
            address = dst_q + i_q;
            data_in = word_q;
            state_d = (i_next < len_q) ? READ : DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         i_q    <= '0;
         word_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  src_q <= src;
                  dst_q <= dst;
                  len_q <= len_clamped;
                  i_q   <= '0;
               end
            end
            CAPTURE: word_q <= data_out;
            WRITE:   i_q    <= i_next[ADDR_W-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_copier.sv
// Scoreboard bench: ram_copier wired to ram_sync, with a word-array model of the RAM.
module tb_ram_copier;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int N  = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src = '0, dst = '0;
   logic [AW:0]   len = '0;
   logic          busy, done, writeOn;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in, data_out;

   logic          ld = 1'b0, tb_we = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [DW-1:0] tb_wdata = '0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;

   always #5 clk = ~clk;

   assign ram_we    = ld ? tb_we    : writeOn;
   assign ram_addr  = ld ? tb_addr  : address;
   assign ram_wdata = ld ? tb_wdata : data_in;

   ram_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .writeOn(writeOn), .address(address),
      .data_in(data_in), .data_out(data_out)
   );

   ram_sync #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
      .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(data_out)
   );

   int total = 0, bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0]    model [N];
   int               rd_q[$];
   logic [AW+DW-1:0] wr_q[$];
   int               exp_lo = 1 << 30, exp_hi = -1;
   int               n_wr = 0;
   logic             mon_en = 1'b0;
   logic [AW+DW-1:0] wexp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: busy/done windows, read addresses and write traffic against the queued expectations.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         check("busy", busy, (cyc >= exp_lo && cyc <= exp_hi));
         check("done", done, (cyc == exp_hi));
         if (writeOn) begin
            n_wr++;
            if (wr_q.size() == 0) check("spurious_write", 1, 0);
            else begin
               wexp = wr_q.pop_front();
               check("write_addr_data", {address, data_in}, wexp);
            end
         end else if (busy && !done) begin
            if (rd_q.size() == 0) check("spurious_read", 1, 0);
            else check("read_addr", address, rd_q.pop_front());
         end else begin
            check("idle_bus", {address, data_in}, 0);
         end
      end
   end

   // Reference copy: word-by-word ascending, reading the model as already updated.
   task automatic issue(input int s, input int d, input int l, input int abort_w, output int a);
      int            nw;
      logic [AW-1:0] r, w;
      @(negedge clk);
      start = 1'b1;
      src   = s[AW-1:0];
      dst   = d[AW-1:0];
      len   = l[AW:0];
      @(posedge clk);
      #1;
      a     = cyc;
      start = 1'b0;
      nw     = (l > N) ? N : l;
      exp_lo = a;
      exp_hi = a + 3 * nw;
      for (int k = 0; k < nw; k++) begin
         if (abort_w >= 0 && k > abort_w) break;
         r = AW'(s + k);
         w = AW'(d + k);
         rd_q.push_back(int'(r));
         rd_q.push_back(int'(r));
         if (abort_w >= 0 && k == abort_w) break;
         wr_q.push_back({w, model[r]});
         model[w] = model[r];
      end
   endtask

   task automatic wait_done(input int limit);
      bit seen = 0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic preload();
      ld = 1'b1;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         tb_we    = 1'b1;
         tb_addr  = AW'(k);
         tb_wdata = (k < 4) ? (32'hC0DE_0000 + DW'(k)) : $urandom;
         model[k] = tb_wdata;
      end
      @(negedge clk);
      tb_we = 1'b0;
      ld    = 1'b0;
   endtask

   task automatic readback();
      ld    = 1'b1;
      tb_we = 1'b0;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         tb_addr = AW'(k);
         @(negedge clk);
         check($sformatf("ram[%0d]", k), data_out, model[k]);
      end
      ld = 1'b0;
   endtask

   task automatic copy_and_check(input int s, input int d, input int l, input string tag);
      int a, w0, nw;
      nw = (l > N) ? N : l;
      w0 = n_wr;
      issue(s, d, l, -1, a);
      wait_done(200);
      check({tag, "_cycles"}, cyc - a + 1, 3 * nw + 1);
      check({tag, "_writes"}, n_wr - w0, nw);
   endtask

   initial begin
      int a, w0;
      #23;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_writeOn", writeOn, 0);
      check("rst_bus", {address, data_in}, 0);
      #9 rst_n = 1'b1;
      mon_en = 1'b1;

      preload();
      copy_and_check(0, 16, 4, "basic4");
      readback();

      // Wrapping source and destination, then a zero-length copy accepted right after DONE.
      copy_and_check(30, 2, 4, "wrap");
      copy_and_check(7, 9, 0, "len0");
      readback();

      copy_and_check($urandom_range(0, 31), $urandom_range(0, 31), 40, "len40");
      readback();

      // Overlapping forward copy with start re-pulsed mid-copy using other operands.
      w0 = n_wr;
      issue(5, 9, 6, -1, a);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start = 1'b1;
         src   = AW'($urandom);
         dst   = AW'($urandom);
         len   = (AW+1)'($urandom_range(1, 40));
      end
      @(negedge clk);
      start = 1'b0;
      wait_done(200);
      check("repulse_cycles", cyc - a + 1, 19);
      check("repulse_writes", n_wr - w0, 6);
      readback();

      // Reset during the WRITE of word 2 of a 4-word copy.
      issue(0, 20, 4, 2, a);
      repeat (8) @(posedge clk);
      #2;
      check("pre_rst_writeOn", writeOn, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_writeOn", writeOn, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_bus", {address, data_in}, 0);
      check("rst_mid_rdq", rd_q.size(), 0);
      check("rst_mid_wrq", wr_q.size(), 0);
      exp_lo = 1 << 30;
      exp_hi = -1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", busy, 0);
      copy_and_check(24, 10, 5, "post_rst");
      readback();

      for (int t = 0; t < 6; t++) begin
         if (t == 3) preload();
         copy_and_check($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 40), "rand");
      end
      readback();

      check("end_rdq", rd_q.size(), 0);
      check("end_wrq", wr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_copier.md
RAM_COPIER -- requirements
Module: ram_copier

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning RAM address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM word width.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port start  input  1  copy request, sampled only in IDLE.
REQ-006 SHALL provide port src  input  ADDR_W  first source word address.
REQ-007 SHALL provide port dst  input  ADDR_W  first destination word address.
REQ-008 SHALL provide port len  input  ADDR_W+1  word count, 0..32.
REQ-009 SHALL provide port busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port writeOn  output  1  RAM write strobe.
REQ-012 SHALL provide port address  output  ADDR_W  RAM address.
REQ-013 SHALL provide port data_in  output  DATA_W  RAM write data.
REQ-014 SHALL provide port data_out  input  DATA_W  RAM synchronous read data, valid one cycle after its address is presented.

Function
REQ-015 SHALL implement states IDLE, READ, CAPTURE, WRITE, DONE.
REQ-016 SHALL, in IDLE with start=1, latch src, dst and min(len,32), clear word index i, and go to READ, or to DONE if the latched len is 0.
REQ-017 SHALL, in READ, drive address=src+i with writeOn=0, then go to CAPTURE.
REQ-018 SHALL, in CAPTURE, hold address=src+i with writeOn=0, register data_out into an internal word register, then go to WRITE.
REQ-019 SHALL, in WRITE, drive address=dst+i, writeOn=1 and data_in=word register, then increment i and go to READ if i+1<len, else to DONE.
REQ-020 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-021 SHALL compute src+i and dst+i modulo 32, so addresses wrap from 31 to 0.
REQ-022 SHALL take exactly 3*len+1 cycles from the accepting edge to the end of the done pulse (1 cycle when len=0).
REQ-023 SHALL ignore start while busy; the latched operands SHALL NOT change mid-copy.
REQ-024 SHALL copy in ascending order with no overlap correction; overlapping ranges with dst>src propagate already-written words by design.
REQ-025 SHALL keep writeOn=0 in every state except WRITE, and drive address=0 and data_in=0 in IDLE and DONE.
REQ-026 SHALL accept a new start in the IDLE cycle immediately after DONE.

Reset
REQ-027 SHALL, on rst_n=0, immediately force the state to IDLE and busy=0, done=0, writeOn=0, address=0, data_in=0, i=0, and clear the word register.
REQ-028 SHALL abandon a copy interrupted by reset without finishing it; words already written remain in the RAM.
REQ-029 SHALL leave reset on the first rising clk edge after rst_n returns to 1, in IDLE.

Structure
REQ-030 SHALL take ADDR_W, DATA_W, DEPTH=32 and the state encoding from a shared package, ram_pkg.
REQ-031 SHALL contain no sub-module; the bench SHALL connect it to the team's 32x32 synchronous RAM, ram_sync.

Verification
REQ-032 SHALL cover: RAM[0..3]=A,B,C,D, start src=0 dst=16 len=4 -> RAM[16..19]=A..D, done 13 cycles after start, exactly 4 writeOn pulses.
REQ-033 SHALL cover: src=30 dst=2 len=4 -> reads from 30,31,0,1 and writes to 2,3,4,5.
REQ-034 SHALL cover: len=0 -> done on the next cycle, no writeOn, busy high for one cycle.
REQ-035 SHALL cover: len=40 -> exactly 32 words copied, done after 97 cycles.
REQ-036 SHALL cover: start re-pulsed with different operands mid-copy -> ignored, and the original copy completes unchanged.
REQ-037 SHALL cover: rst_n low during the WRITE of word 2 of 4 -> writeOn=0 immediately, words 0..1 written and word 2 not, IDLE after release, and a new copy then completes correctly.
